// File: rtl/vga_sync_decoder_if.sv
// Sync-side bundle between a VGA timing source and the sync decoder.
// The master drives the source syncs; the slave returns recovered timing.
interface vga_sync_decoder_if;
  logic       hsync;
  logic       vsync;
  logic       blank_b;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic       blank_err;

  modport master (
    output hsync, vsync, blank_b,
    input  x, y, active, locked, frame_start, sync_err, blank_err
  );

  modport slave (
    input  hsync, vsync, blank_b,
    output x, y, active, locked, frame_start, sync_err, blank_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side sync decoder: recovers x/y from hsync/vsync, locks to
// the configured raster and flags sync or blank timing errors.
module vga_sync_decoder #(
  parameter int unsigned HACTIVE    = 640,
  parameter int unsigned HFP        = 16,
  parameter int unsigned HSYN       = 96,
  parameter int unsigned HBP        = 48,
  parameter int unsigned VACTIVE    = 480,
  parameter int unsigned VFP        = 11,
  parameter int unsigned VSYN       = 2,
  parameter int unsigned VBP        = 32,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_decoder_if.slave vga
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYN + VBP;

  localparam logic [9:0] X_SYNC = 10'(HACTIVE + HFP);
  localparam logic [9:0] X_PRE  = 10'(HACTIVE + HFP - 1);
  localparam logic [9:0] X_LAST = 10'(HTOTAL - 1);
  localparam logic [9:0] X_VIS  = 10'(HACTIVE);
  localparam logic [9:0] Y_SYNC = 10'(VACTIVE + VFP);
  localparam logic [9:0] Y_LAST = 10'(VTOTAL - 1);
  localparam logic [9:0] Y_VIS  = 10'(VACTIVE);

  localparam int              CW         = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(LOCK_LINES - 1);

  typedef enum logic [2:0] {SEARCH, HTRACK, VALIGN, VCHECK, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          hs_q, vs_q, blank_q;
  logic [9:0]    x, y, x_nxt, y_nat, y_nxt;
  logic          locked, sync_err, blank_err, sync_err_nxt;
  logic          hs_fall, vs_fall, x_wrap, visible;
  logic          h_good, h_bad, h_miss, h_err;
  logic          v_good, v_bad, v_miss;

  assign hs_fall = hs_q & ~vga.hsync;
  assign vs_fall = vs_q & ~vga.vsync;

  // A wrap only counts as a new line when hsync did not re-anchor x this cycle.
  assign x_wrap = ~hs_fall & (x == X_LAST);
  assign x_nxt  = hs_fall ? X_SYNC : ((x == X_LAST) ? 10'd0 : x + 10'd1);
  assign y_nat  = x_wrap ? ((y == Y_LAST) ? 10'd0 : y + 10'd1) : y;
  assign y_nxt  = vs_fall ? Y_SYNC : y_nat;

  assign h_good = hs_fall & (x == X_PRE);
  assign h_bad  = hs_fall & ~h_good;
  assign h_miss = (x == X_PRE) & ~hs_fall;
  assign h_err  = h_bad | h_miss;
  assign v_good = vs_fall & (y_nat == Y_SYNC);
  assign v_bad  = vs_fall & ~v_good;
  assign v_miss = x_wrap & (y_nat == Y_SYNC) & ~vs_fall;

  assign visible = (x < X_VIS) & (y < Y_VIS);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_nxt    = state;
    count_nxt    = count;
    sync_err_nxt = 1'b0;
    unique case (state)
      SEARCH: if (hs_fall) begin
        state_nxt = HTRACK;
        count_nxt = '0;
      end
      HTRACK: begin
        if (h_err) begin
          count_nxt = '0;
        end else if (h_good) begin
          if (count == LAST_COUNT) begin
            state_nxt = VALIGN;
            count_nxt = '0;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      VALIGN: begin
        if (h_err) begin
          state_nxt = HTRACK;
          count_nxt = '0;
        end else if (vs_fall) begin
          state_nxt = VCHECK;
        end
      end
      VCHECK: begin
        if (h_err | v_bad)  state_nxt = SEARCH;
        else if (v_good)    state_nxt = LOCKED;
      end
      LOCKED: if (h_err | v_bad | v_miss) begin
        state_nxt    = SEARCH;
        sync_err_nxt = 1'b1;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      count     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      x         <= '0;
      y         <= '0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      blank_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      hs_q      <= vga.hsync;
      vs_q      <= vga.vsync;
      blank_q   <= vga.blank_b;
      x         <= x_nxt;
      y         <= y_nxt;
      locked    <= (state_nxt == LOCKED);
      sync_err  <= sync_err_nxt;
      blank_err <= locked & (blank_q != visible);
    end
  end

  assign vga.x           = x;
  assign vga.y           = y;
  assign vga.locked      = locked;
  assign vga.sync_err    = sync_err;
  assign vga.blank_err   = blank_err;
  assign vga.active      = locked & visible;
  assign vga.frame_start = locked & (x == 10'd0) & (y == 10'd0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 48x20 raster so that many frames fit
// in a short run; the source position of each driven cycle is queued and
// compared against the decoder one clock later.
module tb_vga_sync_decoder;

  localparam int HA = 32, HFP = 4, HSYN = 6, HBP = 6;
  localparam int VA = 12, VFP = 3, VSYN = 2, VBP = 3;
  localparam int HT = HA + HFP + HSYN + HBP;
  localparam int VT = VA + VFP + VSYN + VBP;
  localparam int FRAME = HT * VT;
  localparam int HSS = HA + HFP;
  localparam int VSS = VA + VFP;

  typedef struct {
    int n;
    int f;
    int sx;
    int sy;
    bit vis;
  } sb_entry_t;

  typedef enum {MOD_NONE, MOD_HS_DELAY, MOD_HS_SUPPRESS, MOD_BLANK} mod_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vga_sync_decoder_if bus();

  vga_sync_decoder #(
    .HACTIVE(HA), .HFP(HFP), .HSYN(HSYN), .HBP(HBP),
    .VACTIVE(VA), .VFP(VFP), .VSYN(VSYN), .VBP(VBP),
    .LOCK_LINES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  sb_entry_t sb[$];
  sb_entry_t last_e;
  int   sx = 0, sy = 0, fcnt = 0, n_drv = 0, src_ht = HT;
  mod_t mod_kind = MOD_NONE;
  int   mod_f = -1, mod_line = -1;
  bit   track = 1'b0, expect_unlocked = 1'b0;
  int   cnt_sync = 0, cnt_blank = 0, fs_count = 0, last_fs_n = -1;
  bit   got_se = 1'b0;
  sb_entry_t se_e;
  logic se_locked;
  logic obs_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one source cycle, push its position, then observe the decoder.
  task automatic step();
    sb_entry_t e;
    bit on_line, hs, vs, bl;
    on_line = (fcnt == mod_f) && (sy == mod_line);
    hs = !(sx >= HSS && sx < HSS + HSYN);
    if (on_line && mod_kind == MOD_HS_DELAY && sx == HSS) hs = 1'b1;
    if (on_line && mod_kind == MOD_HS_SUPPRESS) hs = 1'b1;
    vs = !(sy >= VSS && sy < VSS + VSYN);
    bl = (sx < HA) && (sy < VA);
    if (on_line && mod_kind == MOD_BLANK && sx >= 10 && sx <= 12) bl = 1'b0;
    bus.hsync   = hs;
    bus.vsync   = vs;
    bus.blank_b = bl;
    e.n   = n_drv;
    e.f   = fcnt;
    e.sx  = sx;
    e.sy  = sy;
    e.vis = (sx < HA) && (sy < VA);
    sb.push_back(e);
    n_drv++;
    sx++;
    if (sx == src_ht) begin
      sx = 0;
      sy++;
      if (sy == VT) begin
        sy = 0;
        fcnt++;
      end
    end

    @(negedge clk);
    e = sb.pop_front();
    last_e = e;
    obs_locked = bus.locked;
    if (track) begin
      check("x", 32'(bus.x), 32'(e.sx));
      check("y", 32'(bus.y), 32'(e.sy));
      check("active", 32'(bus.active), 32'(e.vis));
      check("frame_start", 32'(bus.frame_start), 32'(e.sx == 0 && e.sy == 0));
      check("locked_hold", 32'(bus.locked), 32'd1);
      check("no_sync_err", 32'(bus.sync_err), 32'd0);
    end
    if (expect_unlocked) begin
      check("stay_unlocked", 32'(bus.locked), 32'd0);
      check("no_sync_err_unlocked", 32'(bus.sync_err), 32'd0);
    end
    if (bus.sync_err === 1'b1) begin
      cnt_sync++;
      if (!got_se) begin
        got_se    = 1'b1;
        se_e      = e;
        se_locked = bus.locked;
      end
    end
    if (bus.blank_err === 1'b1) cnt_blank++;
    if (bus.locked !== 1'b1) last_fs_n = -1;
    if (bus.frame_start === 1'b1) begin
      fs_count++;
      if (track && last_fs_n >= 0) check("fs_period", 32'(e.n - last_fs_n), 32'(FRAME));
      last_fs_n = e.n;
    end
  endtask

  task automatic run_until(input int line);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(sx == 0 && sy == line) && guard < 2 * FRAME);
    check("run_until_reached", 32'(sx == 0 && sy == line), 32'd1);
  endtask

  task automatic wait_lock(input int budget, output sb_entry_t at);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (obs_locked === 1'b1) got = 1'b1;
    end
    at = last_e;
    check("lock_within_budget", 32'(got), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 32'(bus.x), 32'd0);
    check({tag, "_y"}, 32'(bus.y), 32'd0);
    check({tag, "_locked"}, 32'(bus.locked), 32'd0);
    check({tag, "_sync_err"}, 32'(bus.sync_err), 32'd0);
    check({tag, "_blank_err"}, 32'(bus.blank_err), 32'd0);
    check({tag, "_active"}, 32'(bus.active), 32'd0);
    check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
  endtask

  task automatic sync_fault(input string tag, input mod_t kind);
    sb_entry_t e;
    int f0;
    run_until(2);
    f0       = fcnt;
    mod_kind = kind;
    mod_f    = f0;
    mod_line = 2;
    track    = 1'b0;
    cnt_sync = 0;
    got_se   = 1'b0;
    repeat (HT) step();
    check({tag, "_sync_err_pulses"}, 32'(cnt_sync), 32'd1);
    check({tag, "_err_at_x"}, 32'(se_e.sx), 32'(HSS));
    check({tag, "_err_on_line"}, 32'(se_e.sy), 32'd2);
    check({tag, "_locked_dropped"}, 32'(se_locked), 32'd0);
    wait_lock(3 * FRAME, e);
    check({tag, "_relock_frame"}, 32'(e.f), 32'(f0 + 1));
    check({tag, "_relock_pos"}, 32'(e.sy * HT + e.sx), 32'(VSS * HT));
    mod_kind = MOD_NONE;
    track    = 1'b1;
    repeat (FRAME) step();
    check({tag, "_single_sync_err"}, 32'(cnt_sync), 32'd1);
  endtask

  initial begin
    sb_entry_t e;
    int f0;
    bus.hsync   = 1'b1;
    bus.vsync   = 1'b1;
    bus.blank_b = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Clean stream from reset: lock on the first v_good, then track two frames.
    wait_lock(3 * FRAME, e);
    check("t1_lock_frame", 32'(e.f), 32'd1);
    check("t1_lock_pos", 32'(e.sy * HT + e.sx), 32'(VSS * HT));
    track    = 1'b1;
    fs_count = 0;
    repeat (2 * FRAME) step();
    check("t1_frame_starts", 32'(fs_count), 32'd2);
    check("t1_sync_err_count", 32'(cnt_sync), 32'd0);
    check("t1_blank_err_count", 32'(cnt_blank), 32'd0);

    // blank_b dropped for three visible pixels on line 5.
    run_until(5);
    mod_kind  = MOD_BLANK;
    mod_f     = fcnt;
    mod_line  = 5;
    cnt_blank = 0;
    repeat (FRAME) step();
    mod_kind = MOD_NONE;
    check("t4_blank_err_pulses", 32'(cnt_blank), 32'd3);
    check("t4_sync_err_count", 32'(cnt_sync), 32'd0);

    sync_fault("t2_delay", MOD_HS_DELAY);
    sync_fault("t3_suppress", MOD_HS_SUPPRESS);

    // One-cycle reset mid-frame.
    run_until(6);
    track = 1'b0;
    reset = 1'b0;
    step();
    check_reset_outputs("t6_midreset");
    reset    = 1'b1;
    f0       = fcnt;
    cnt_sync = 0;
    wait_lock(3 * FRAME, e);
    check("t6_relock_frame", 32'(e.f), 32'(f0 + 1));
    check("t6_relock_pos", 32'(e.sy * HT + e.sx), 32'(VSS * HT));
    track = 1'b1;
    repeat (FRAME) step();
    check("t6_sync_err_count", 32'(cnt_sync), 32'd0);

    // Source lines one pixel too long: never leaves HTRACK.
    track  = 1'b0;
    reset  = 1'b0;
    step();
    reset  = 1'b1;
    src_ht = HT + 1;
    sx     = 0;
    sy     = 0;
    expect_unlocked = 1'b1;
    cnt_sync        = 0;
    repeat (3 * (HT + 1) * VT) step();
    expect_unlocked = 1'b0;
    check("t5_sync_err_count", 32'(cnt_sync), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
